// File: rtl/addsub_result_fifo_if.sv
// -----------------------------------------------------------------------------
// addsub_result_fifo_if
// Bundles the producer-side and consumer-side handshake signals of
// addsub_result_fifo, together with its occupancy and drop status.
//
//   slave  : the FIFO side (accepts in_*, presents out_*, count, drop_err)
//   master : the environment side (drives in_*, out_ready, observes the rest)
//
// Parameters:
//   DEPTH  - number of FIFO entries (power of two, >= 2)
//   WIDTH  - result width, matches the adder/subtractor Sum width
// -----------------------------------------------------------------------------
interface addsub_result_fifo_if #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   // producer side
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_sum;
   logic             in_cout;
   logic             in_op;

   // consumer side
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_op;
   logic             out_zero;
   logic             out_borrow;

   // status
   logic [CW-1:0]    count;
   logic             drop_err;

   modport slave (
      input  in_valid, in_sum, in_cout, in_op, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_op,
             out_zero, out_borrow, count, drop_err
   );

   modport master (
      output in_valid, in_sum, in_cout, in_op, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_op,
             out_zero, out_borrow, count, drop_err
   );
endinterface

// File: rtl/addsub_result_fifo.sv
// -----------------------------------------------------------------------------
// addsub_result_fifo
// Captures {op, cout, sum} results from adder_subtractor_8bit into a small
// synchronous show-ahead FIFO drained with a valid/ready handshake. Zero and
// borrow flags are derived from the head entry; any result presented while
// the FIFO is full is discarded and recorded in a sticky drop_err flag.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous, active-high; clears control state only
//   bus  - addsub_result_fifo_if.slave
//            in_valid/in_ready/in_sum/in_cout/in_op   producer handshake
//            out_valid/out_ready/out_sum/out_cout/out_op consumer handshake
//            out_zero   head valid and sum == 0
//            out_borrow head valid, subtract, and no carry-out
//            count      occupancy 0..DEPTH
//            drop_err   sticky, set when in_valid && !in_ready
// -----------------------------------------------------------------------------
module addsub_result_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   addsub_result_fifo_if.slave   bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = WIDTH + 2;   // {op, cout, sum}
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic          drop_q;

   logic          in_ready;
   logic          out_valid;
   logic          push;
   logic          pop;
   logic [EW-1:0] head;

   // Handshake readiness depends on registered occupancy only, so a pop at
   // full never frees a slot for a push in the same cycle.
   assign in_ready  = (count_q != FULL);
   assign out_valid = (count_q != '0);
   assign push      = bus.in_valid && in_ready;
   assign pop       = out_valid && bus.out_ready;

   // Storage is data only and deliberately not reset.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem[wr_ptr] <= {bus.in_op, bus.in_cout, bus.in_sum};
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         drop_q  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (bus.in_valid && !in_ready) begin
            drop_q <= 1'b1;
         end
      end
   end

   // Show-ahead head entry; all data and flags forced to 0 while empty.
   always_comb begin
      head = '0;
      if (out_valid) begin
         head = mem[rd_ptr];
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid;
   assign bus.out_sum    = head[WIDTH-1:0];
   assign bus.out_cout   = head[WIDTH];
   assign bus.out_op     = head[WIDTH+1];
   assign bus.out_zero   = out_valid && (head[WIDTH-1:0] == '0);
   assign bus.out_borrow = out_valid && head[WIDTH+1] && !head[WIDTH];
   assign bus.count      = count_q;
   assign bus.drop_err   = drop_q;
endmodule
